// File: rtl/braille_cell_driver.sv
// Braille cell driver: accepts a 4-bit symbol over valid/ready, shows its 6-dot
// cell for HOLD_CYCLES, blanks for GAP_CYCLES, then pulses done.
module braille_cell_driver #(
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 250,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  logic [3:0] sym_data,
    output logic       sym_ready,
    input  logic       abort,
    output logic [5:0] dots,
    output logic       dots_active,
    output logic       busy,
    output logic       done,
    output logic [3:0] last_sym
);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_e;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [5:0]       dots_q, dots_d;
    logic             done_q, done_d;
    logic [3:0]       last_q, last_d;

    // Must remain the exact inverse of the trainer's decoder table.
    function automatic logic [5:0] cell_of(input logic [3:0] idx);
        case (idx)
            4'h0: cell_of = 6'b000001;
            4'h1: cell_of = 6'b000101;
            4'h2: cell_of = 6'b000011;
            4'h3: cell_of = 6'b001011;
            4'h4: cell_of = 6'b001001;
            4'h5: cell_of = 6'b000111;
            4'h6: cell_of = 6'b001111;
            4'h7: cell_of = 6'b001101;
            4'h8: cell_of = 6'b000110;
            4'h9: cell_of = 6'b001110;
            4'hA: cell_of = 6'b010101;
            4'hB: cell_of = 6'b011001;
            4'hC: cell_of = 6'b010111;
            4'hD: cell_of = 6'b010110;
            4'hE: cell_of = 6'b110001;
            default: cell_of = 6'b111011;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dots_d  = dots_q;
        done_d  = 1'b0;
        last_d  = last_q;
        if (abort) begin
            state_d = IDLE;
            timer_d = '0;
            dots_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (sym_valid) begin
                    state_d = SHOW;
                    dots_d  = cell_of(sym_data);
                    last_d  = sym_data;
                    timer_d = HOLD_LD;
                end
                SHOW: if (timer_q == '0) begin
                    dots_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                        timer_d = GAP_LD;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
                GAP: if (timer_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    dots_d  = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            dots_q  <= '0;
            done_q  <= 1'b0;
            last_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dots_q  <= dots_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign sym_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign dots_active = (state_q == SHOW);
    assign dots        = dots_q;
    assign done        = done_q;
    assign last_sym    = last_q;

endmodule

// File: tb/tb_braille_cell_driver.sv
// Directed bench: instance a (HOLD=4, GAP=2) and instance b (HOLD=4, GAP=0).
module tb_braille_cell_driver;

    localparam int H = 4;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_valid = 0, a_abort = 0, a_ready, a_act, a_busy, a_done;
    logic [3:0] a_data = 0, a_last;
    logic [5:0] a_dots;
    logic       b_valid = 0, b_abort = 0, b_ready, b_act, b_busy, b_done;
    logic [3:0] b_data = 0, b_last;
    logic [5:0] b_dots;

    braille_cell_driver #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .sym_valid(a_valid), .sym_data(a_data),
        .sym_ready(a_ready), .abort(a_abort), .dots(a_dots), .dots_active(a_act),
        .busy(a_busy), .done(a_done), .last_sym(a_last));

    braille_cell_driver #(.HOLD_CYCLES(H), .GAP_CYCLES(0), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .sym_valid(b_valid), .sym_data(b_data),
        .sym_ready(b_ready), .abort(b_abort), .dots(b_dots), .dots_active(b_act),
        .busy(b_busy), .done(b_done), .last_sym(b_last));

    logic [5:0] tbl [16] = '{6'b000001, 6'b000101, 6'b000011, 6'b001011,
                             6'b001001, 6'b000111, 6'b001111, 6'b001101,
                             6'b000110, 6'b001110, 6'b010101, 6'b011001,
                             6'b010111, 6'b010110, 6'b110001, 6'b111011};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decoder: inverse lookup of the bench's own table.
    function automatic logic [4:0] decode(input logic [5:0] d);
        decode = 5'h1F;
        for (int i = 0; i < 16; i++)
            if (tbl[i] == d) decode = 5'(i);
    endfunction

    task automatic wait_idle_a();
        for (int i = 0; i < 50 && !a_ready; i++) tick();
        chk("wait_idle", a_ready, 1);
    endtask

    // Full cell on instance a from IDLE: H shown cycles, G blank, then done.
    task automatic run_sym(input logic [3:0] s, input bit full);
        a_valid = 1; a_data = s;
        if (full) chk("ready_pre", a_ready, 1);
        tick();
        a_valid = 0; a_data = ~s;
        for (int c = 0; c < H; c++) begin
            chk($sformatf("dots_%0h_%0d", s, c), a_dots, tbl[s]);
            if (full) begin
                chk("decode", decode(a_dots), {1'b0, s});
                chk("active", a_act, 1);
                chk("ready_show", a_ready, 0);
                chk("done_show", a_done, 0);
            end
            tick();
        end
        for (int c = 0; c < G; c++) begin
            chk("gap_dots", a_dots, 0);
            if (full) begin
                chk("gap_busy", a_busy, 1);
                chk("gap_active", a_act, 0);
            end
            tick();
        end
        chk("done_pulse", a_done, 1);
        chk("ready_post", a_ready, 1);
        chk("last_sym", a_last, s);
        tick();
        chk("done_clear", a_done, 0);
    endtask

    initial begin
        #2;
        chk("rst_dots", a_dots, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_last", a_last, 0);
        #10 rst_n = 1;
        tick();
        chk("rst_ready", a_ready, 1);

        // Idle data changes without valid do nothing.
        a_data = 4'h7; tick();
        chk("no_xfer", a_busy, 0);

        run_sym(4'hA, 1'b1);
        for (int s = 0; s < 16; s++) run_sym(4'(s), 1'b0);

        // Back-to-back with valid held: second transfer lands in the done cycle.
        a_valid = 1; a_data = 4'h3; tick();
        chk("b2b_dots0", a_dots, 6'b001011);
        a_data = 4'hE;
        for (int n = 1; n <= 6; n++) begin
            if (n == 3) chk("b2b_hold", a_dots, 6'b001011);
            if (n < 6) chk("b2b_busy", a_busy, 1);
            tick();
        end
        chk("b2b_done", a_done, 1);
        chk("b2b_ready", a_ready, 1);
        tick();
        chk("b2b_dots1", a_dots, 6'b110001);
        chk("b2b_last", a_last, 4'hE);
        a_valid = 0;
        wait_idle_a();
        tick();

        // Abort during the 2nd SHOW cycle.
        a_valid = 1; a_data = 4'h5; tick();
        a_valid = 0; tick();
        chk("ab_show2", a_dots, 6'b000111);
        a_abort = 1; tick();
        a_abort = 0;
        chk("ab_dots", a_dots, 0);
        chk("ab_ready", a_ready, 1);
        chk("ab_done", a_done, 0);
        chk("ab_last", a_last, 4'h5);
        tick();
        chk("ab_done2", a_done, 0);
        // Abort in IDLE blocks a transfer.
        a_abort = 1; a_valid = 1; a_data = 4'h9; tick();
        a_abort = 0; a_valid = 0;
        chk("ab_idle_blk", a_busy, 0);
        run_sym(4'h7, 1'b1);

        // No-gap instance: 4 shown cycles then straight to IDLE with done.
        b_valid = 1; b_data = 4'hF; tick();
        b_valid = 0;
        for (int c = 0; c < H; c++) begin
            chk("g0_dots", b_dots, 6'b111011);
            tick();
        end
        chk("g0_dots_off", b_dots, 0);
        chk("g0_busy", b_busy, 0);
        chk("g0_done", b_done, 1);
        chk("g0_last", b_last, 4'hF);
        tick();
        chk("g0_done_clr", b_done, 0);

        // Asynchronous reset mid-SHOW.
        a_valid = 1; a_data = 4'hC; tick();
        a_valid = 0; tick();
        chk("mid_dots", a_dots, 6'b010111);
        rst_n = 0; #1;
        chk("mr_dots", a_dots, 0);
        chk("mr_busy", a_busy, 0);
        chk("mr_done", a_done, 0);
        chk("mr_last", a_last, 0);
        #4 rst_n = 1;
        tick();
        chk("mr_ready", a_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
